// File: rtl/cl_adder_pkg.sv
// Shared constants and helpers for the carry-lookahead adder.
// Operands are processed in fixed-size lookahead groups.
package cl_adder_pkg;

  localparam int GROUP_WIDTH = 4;

  // Round a width up to a whole number of lookahead groups.
  function automatic int padded_width(input int width);
    return ((width + GROUP_WIDTH - 1) / GROUP_WIDTH) * GROUP_WIDTH;
  endfunction

endpackage

// File: rtl/cla_group4.sv
// Four-bit carry-lookahead group: closed-form carries into each bit of the group,
// plus the group generate/propagate terms used by the second-level lookahead.
module cla_group4
  import cl_adder_pkg::*;
(
  input  logic [GROUP_WIDTH-1:0] g,
  input  logic [GROUP_WIDTH-1:0] p,
  input  logic                   cin,
  output logic [GROUP_WIDTH-1:0] carries,
  output logic                   grp_g,
  output logic                   grp_p
);

  // carries[i] is the carry into bit i of the group; carries[0] is cin itself.
  assign carries[0] = cin;
  assign carries[1] = g[0] | (p[0] & cin);
  assign carries[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign carries[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                    | (p[2] & p[1] & p[0] & cin);

  assign grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]);
  assign grp_p = &p;

endmodule

// File: rtl/cl_adder.sv
// Registered two-level carry-lookahead adder: {carry_o, result_o} = a_i + b_i,
// one cycle of latency, new result every cycle.
module cl_adder
  import cl_adder_pkg::*;
#(
  parameter int Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic [Width-1:0] result_o,
  output logic             carry_o
);

  localparam int PadWidth  = padded_width(Width);
  localparam int NumGroups = PadWidth / GROUP_WIDTH;

  logic [PadWidth-1:0]  a_pad_s;
  logic [PadWidth-1:0]  b_pad_s;
  logic [PadWidth-1:0]  g_s;
  logic [PadWidth-1:0]  p_s;
  logic [PadWidth:0]    c_s;
  logic [NumGroups:0]   grp_cin_s;
  logic [NumGroups-1:0] grp_g_s;
  logic [NumGroups-1:0] grp_p_s;
  logic [Width-1:0]     sum_s;
  logic [Width-1:0]     result_r;
  logic                 carry_r;

  assign a_pad_s = PadWidth'(a_i);
  assign b_pad_s = PadWidth'(b_i);
  assign g_s     = a_pad_s & b_pad_s;
  assign p_s     = a_pad_s ^ b_pad_s;

  for (genvar k = 0; k < NumGroups; k++) begin : gen_group
    cla_group4 u_group (
      .g       (g_s[k*GROUP_WIDTH +: GROUP_WIDTH]),
      .p       (p_s[k*GROUP_WIDTH +: GROUP_WIDTH]),
      .cin     (grp_cin_s[k]),
      .carries (c_s[k*GROUP_WIDTH +: GROUP_WIDTH]),
      .grp_g   (grp_g_s[k]),
      .grp_p   (grp_p_s[k])
    );
  end

  // The carry into the padded top only matters when Width fills the last group.
  assign c_s[PadWidth] = grp_cin_s[NumGroups];

  logic term_s;
  logic carry_s;

  // Second-level lookahead: each group carry-in as a flat sum of products of
  // group G/P terms, so no carry ever ripples from one group into the next.
  always_comb begin
    grp_cin_s = {(NumGroups + 1){1'b0}};
    term_s    = 1'b0;
    carry_s   = 1'b0;
    for (int k = 1; k <= NumGroups; k++) begin
      carry_s = 1'b0;
      for (int j = 0; j < k; j++) begin
        term_s = grp_g_s[j];
        for (int m = j + 1; m < k; m++) begin
          term_s = term_s & grp_p_s[m];
        end
        carry_s = carry_s | term_s;
      end
      grp_cin_s[k] = carry_s;
    end
  end

  assign sum_s = p_s[Width-1:0] ^ c_s[Width-1:0];

  // Output registers; carry_o is the carry into bit Width, not the padded top.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      result_r <= {Width{1'b0}};
      carry_r  <= 1'b0;
    end else begin
      result_r <= sum_s;
      carry_r  <= c_s[Width];
    end
  end

  assign result_o = result_r;
  assign carry_o  = carry_r;

endmodule

// File: tb/tb_cl_adder.sv
// Self-checking bench for cl_adder at several widths, driven in lockstep with a
// shared clock/reset and a scoreboard of behavioral a+b results.
module tb_cl_adder;

  logic clk;
  logic rst;

  logic [0:0]  a_1,  b_1,  res_1;  logic cy_1;
  logic [3:0]  a_4,  b_4,  res_4;  logic cy_4;
  logic [5:0]  a_6,  b_6,  res_6;  logic cy_6;
  logic [6:0]  a_7,  b_7,  res_7;  logic cy_7;
  logic [15:0] a_16, b_16, res_16; logic cy_16;
  logic [31:0] a_32, b_32, res_32; logic cy_32;

  cl_adder #(.Width(1))  u_w1  (.clk_i(clk), .rst_i(rst), .a_i(a_1),  .b_i(b_1),  .result_o(res_1),  .carry_o(cy_1));
  cl_adder #(.Width(4))  u_w4  (.clk_i(clk), .rst_i(rst), .a_i(a_4),  .b_i(b_4),  .result_o(res_4),  .carry_o(cy_4));
  cl_adder #(.Width(6))  u_w6  (.clk_i(clk), .rst_i(rst), .a_i(a_6),  .b_i(b_6),  .result_o(res_6),  .carry_o(cy_6));
  cl_adder #(.Width(7))  u_w7  (.clk_i(clk), .rst_i(rst), .a_i(a_7),  .b_i(b_7),  .result_o(res_7),  .carry_o(cy_7));
  cl_adder #(.Width(16)) u_w16 (.clk_i(clk), .rst_i(rst), .a_i(a_16), .b_i(b_16), .result_o(res_16), .carry_o(cy_16));
  cl_adder #(.Width(32)) u_w32 (.clk_i(clk), .rst_i(rst), .a_i(a_32), .b_i(b_32), .result_o(res_32), .carry_o(cy_32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  e1;
    logic [4:0]  e4;
    logic [6:0]  e6;
    logic [7:0]  e7;
    logic [16:0] e16;
    logic [32:0] e32;
  } exp_t;

  exp_t  sb_q[$];
  int    checks = 0;
  int    errors = 0;
  string cur_tag = "init";

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_all();
    exp_t e;
    e.e1  = {1'b0, a_1}  + {1'b0, b_1};
    e.e4  = {1'b0, a_4}  + {1'b0, b_4};
    e.e6  = {1'b0, a_6}  + {1'b0, b_6};
    e.e7  = {1'b0, a_7}  + {1'b0, b_7};
    e.e16 = {1'b0, a_16} + {1'b0, b_16};
    e.e32 = {1'b0, a_32} + {1'b0, b_32};
    sb_q.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_scoreboard: observed empty queue expected one entry", cur_tag);
    end else begin
      e = sb_q.pop_front();
      chk({cur_tag, "_w1"},  65'({cy_1,  res_1}),  65'(e.e1));
      chk({cur_tag, "_w4"},  65'({cy_4,  res_4}),  65'(e.e4));
      chk({cur_tag, "_w6"},  65'({cy_6,  res_6}),  65'(e.e6));
      chk({cur_tag, "_w7"},  65'({cy_7,  res_7}),  65'(e.e7));
      chk({cur_tag, "_w16"}, 65'({cy_16, res_16}), 65'(e.e16));
      chk({cur_tag, "_w32"}, 65'({cy_32, res_32}), 65'(e.e32));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_w1"},  65'({cy_1,  res_1}),  65'd0);
    chk({tag, "_w4"},  65'({cy_4,  res_4}),  65'd0);
    chk({tag, "_w6"},  65'({cy_6,  res_6}),  65'd0);
    chk({tag, "_w7"},  65'({cy_7,  res_7}),  65'd0);
    chk({tag, "_w16"}, 65'({cy_16, res_16}), 65'd0);
    chk({tag, "_w32"}, 65'({cy_32, res_32}), 65'd0);
  endtask

  task automatic set_ops(input logic [63:0] a, input logic [63:0] b);
    a_1  = a[0:0];  b_1  = b[0:0];
    a_4  = a[3:0];  b_4  = b[3:0];
    a_6  = a[5:0];  b_6  = b[5:0];
    a_7  = a[6:0];  b_7  = b[6:0];
    a_16 = a[15:0]; b_16 = b[15:0];
    a_32 = a[31:0]; b_32 = b[31:0];
  endtask

  initial begin
    rst = 1'b1;
    set_ops(64'h5, 64'h6);
    #12;
    chk_all_zero("reset_hold");

    // Release between edges; the first edge captures the inputs present then.
    @(negedge clk);
    rst = 1'b0;
    set_ops(64'h3, 64'h1);
    push_all();
    cur_tag = "first_after_reset";
    tick();

    set_ops(64'h0, 64'h0);
    push_all();
    cur_tag = "zero_plus_zero";
    tick();

    a_4 = 4'h7;  b_4 = 4'h8;
    a_6 = 6'h20; b_6 = 6'h10;
    a_7 = 7'h7F; b_7 = 7'h01;
    a_1 = 1'b1;  b_1 = 1'b1;
    a_16 = 16'h0F0F; b_16 = 16'h00F1;
    a_32 = 32'h8000_0000; b_32 = 32'h7FFF_FFFF;
    push_all();
    cur_tag = "mixed_no_wrap";
    tick();

    set_ops(64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
    push_all();
    cur_tag = "all_ones_plus_one";
    tick();
    chk("wrap_w16_literal", 65'({cy_16, res_16}), 65'h1_0000);
    chk("wrap_w6_literal",  65'({cy_6,  res_6}),  65'h40);

    a_6 = 6'h20; b_6 = 6'h10;
    push_all();
    cur_tag = "w6_no_carry";
    tick();
    chk("w6_0x20_plus_0x10", 65'({cy_6, res_6}), 65'h30);

    a_4 = 4'h4; b_4 = 4'hF;
    push_all();
    cur_tag = "w4_4_plus_f";
    tick();
    chk("w4_4_plus_f_literal", 65'({cy_4, res_4}), 65'h13);

    // Reset asserted mid-cycle while the outputs hold 3/1; the in-flight sum is discarded.
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("async_reset");
    sb_q.delete();
    @(posedge clk);
    #1;
    chk_all_zero("reset_across_edge");
    @(negedge clk);
    rst = 1'b0;
    a_4 = 4'h7; b_4 = 4'h8;
    push_all();
    cur_tag = "after_mid_reset";
    tick();
    chk("w4_7_plus_8_literal", 65'({cy_4, res_4}), 65'h0F);

    // Back-to-back random operands on every width at once.
    cur_tag = "random";
    for (int i = 0; i < 10000; i++) begin
      set_ops({$urandom(), $urandom()}, {$urandom(), $urandom()});
      push_all();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cl_adder.md
CL_ADDER -- requirements
Module: cl_adder

Interface
REQ-001 The block SHALL provide parameter Width, default 4, giving the operand and result width in bits; legal range is 1 to 64.
REQ-002 The block SHALL provide port clk_i, input, 1 bit, the single clock; all state is rising-edge triggered.
REQ-003 The block SHALL provide port rst_i, input, 1 bit, asynchronous active-high reset.
REQ-004 The block SHALL provide port a_i, input, Width bits, unsigned addend A.
REQ-005 The block SHALL provide port b_i, input, Width bits, unsigned addend B.
REQ-006 The block SHALL provide port result_o, output, Width bits, registered sum (A+B) mod 2^Width.
REQ-007 The block SHALL provide port carry_o, output, 1 bit, registered carry-out of bit Width-1.

Function
REQ-008 The block SHALL compute {carry_o, result_o} = a_i + b_i as an unsigned Width+1-bit sum; carry-in is fixed at 0.
REQ-009 The block SHALL compute per-bit generate g = a&b and propagate p = a^b, and sum bit s[i] = p[i] ^ c[i].
REQ-010 The block SHALL derive carries by lookahead, not ripple: 4-bit groups compute c[i+1] = g[i] | p[i]&c[i] expanded in closed form within the group, plus group generate G and group propagate P.
REQ-011 The block SHALL combine group G/P with a second-level lookahead unit to produce each group carry-in; there is no ripple path between groups.
REQ-012 If Width is not a multiple of 4, the block SHALL zero-extend the operands internally to the next multiple of 4 and take carry_o from the carry into bit Width, not from the padded top.
REQ-013 The block SHALL register result_o and carry_o on the rising edge of clk_i; latency is exactly 1 cycle from a_i/b_i to the outputs, with a new result every cycle (throughput 1).
REQ-014 The block SHALL have no handshake and no enable; the inputs are sampled every rising edge.
REQ-015 Overflow SHALL wrap: all-ones + 1 gives result_o = 0 and carry_o = 1.

Reset
REQ-016 While rst_i is high, result_o and carry_o SHALL be 0 immediately, independent of clk_i.
REQ-017 On the first rising edge after rst_i deasserts, the outputs SHALL capture the sum of the inputs present at that edge.
REQ-018 Asserting rst_i mid-stream SHALL discard the in-flight result; no stale value SHALL appear after reset release.

Structure
REQ-019 The package cl_adder_pkg SHALL hold the constant GROUP_WIDTH = 4 and a function computing the padded width (ceil(Width/4)*4).
REQ-020 The block SHALL instantiate one sub-module, cla_group4: a combinational block with inputs 4-bit g, 4-bit p and cin, and outputs 4-bit carries, group G and group P; it is instantiated once per group.
REQ-021 The second-level lookahead unit and the output registers SHALL reside in cl_adder.

Verification
REQ-022 Width=4, a_i=4'h4, b_i=4'hF -> one cycle later result_o=4'h3, carry_o=1.
REQ-023 Width=4, a_i=4'h0, b_i=4'h0 -> result_o=0, carry_o=0; a_i=4'h7, b_i=4'h8 -> result_o=4'hF, carry_o=0.
REQ-024 Width=16, a_i=16'hFFFF, b_i=16'h0001 -> result_o=16'h0000, carry_o=1, checking the full cross-group carry chain.
REQ-025 Width=6, a_i=6'h3F, b_i=6'h01 -> result_o=0, carry_o=1, checking the padding rule; a_i=6'h20, b_i=6'h10 -> result_o=6'h30, carry_o=0.
REQ-026 Reset check: assert rst_i asynchronously between clock edges while the outputs hold 4'h3/1 -> both outputs go to 0 at once; after release the next edge shows the current sum.
REQ-027 Random check: at least 10k random back-to-back operand pairs for Width in {1,4,7,32}, each compared against a behavioral a+b one cycle later.
